jk_bank_arbiter: RTL and testbench
==================================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, number of JK flip-flops in the shared register bank.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req  input  2  per-requester command request; bit i belongs to requester i.
REQ-005 op0, op1  input  2 each  command of requester 0/1: HOLD=0, SET=1, CLR=2, TOG=3.
REQ-006 mask0, mask1  input  WIDTH each  bits of the bank affected by requester 0/1's command.
REQ-007 ack  output  2  one-cycle completion pulse per requester.
REQ-008 busy  output  1  high whenever FSM is not IDLE.
REQ-009 q  output  WIDTH  bank state; qn  output  WIDTH  bitwise complement of q.

Function
REQ-010 FSM states shall be IDLE, EXEC and ACK; one command shall be serviced at a time.
REQ-011 IDLE: if any req bit high, the FSM shall latch winner index, its op and its mask, then go to EXEC; otherwise it shall stay in IDLE.
REQ-012 Arbitration shall be round-robin: on a tie, the requester not served last shall win; after reset, requester 0 shall have priority.
REQ-013 The priority pointer shall update only when leaving ACK, to the requester that was not just served.
REQ-014 EXEC: each masked bit shall receive J/K per op (SET: J=1 K=0; CLR: J=0 K=1; TOG: J=1 K=1; HOLD: J=0 K=0); unmasked bits shall hold; q shall update at the end of the EXEC cycle; next state ACK.
REQ-015 ACK: ack[winner] shall be high for exactly this cycle; next state IDLE.
REQ-016 Latency: req sampled in cycle n, q updated at the edge ending cycle n+1, ack high in cycle n+2.
REQ-017 Requesters shall hold op/mask stable until ack and shall drop req the cycle after ack; the block shall ignore req and op/mask changes during EXEC and ACK.
REQ-018 qn shall equal ~q in every cycle, including the reset cycle and the cycle following it.
REQ-019 An all-zero mask or op=HOLD shall still complete the full IDLE-EXEC-ACK sequence with q unchanged.
REQ-020 The loser of a simultaneous request shall be granted in the next IDLE cycle if its req is still high.

Reset
REQ-021 With rst low at a clock edge: FSM shall enter IDLE, q=0, qn=all-ones, ack=0, busy=0, priority shall go to requester 0, and the statistics counter (if compiled in) shall be 0.
REQ-022 Reset asserted during EXEC or ACK shall abort the command with no ack pulse; q shall still go to 0.

Configuration
REQ-023 Macro JK_BANK_STATS_EN: when defined, add output op_count (16 bits), which increments on every ACK cycle and saturates at 0xFFFF; when undefined, the port and counter shall be absent and all other behaviour shall be identical.

Structure
REQ-024 Package jk_bank_pkg shall hold the op encoding (OP_HOLD, OP_SET, OP_CLR, OP_TOG), the FSM state encoding, and the default WIDTH constant.
REQ-025 The two-way round-robin arbiter shall be a sub-module, jk_rr_arb (inputs: req, priority pointer; output: one-hot grant); the bank and FSM shall stay in the top module.

Verification
REQ-026 Reset, then req=01, op0=SET, mask0=0x0F -> q=0x0F, qn=0xF0 at cycle 2; ack=01 at cycle 2 only.
REQ-027 With q=0x0F: req=11, op0=TOG, mask0=0xFF, op1=CLR, mask1=0x01 -> requester 1 served first (0 served last): q=0x0E; then requester 0: q=0xF1; acks 10 then 01.
REQ-028 req0 held continuously while requester 1 requests -> grants alternate 0,1,0,1 with no starvation.
REQ-029 rst driven low during EXEC of a SET 0xFF -> q=0x00, no ack, busy=0 the next cycle.
REQ-030 op=HOLD with mask=0xFF -> q unchanged and ack after 2 cycles; with JK_BANK_STATS_EN, 65540 commands -> op_count=0xFFFF.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK register-bank arbiter.
package jk_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SET  = 2'd1,
        OP_CLR  = 2'd2,
        OP_TOG  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/jk_rr_arb.sv
// Two-way round-robin arbiter: prio names the requester that wins a tie.
module jk_rr_arb (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two requesters share a bank of JK flip-flops, one command per IDLE-EXEC-ACK pass.
// Optional JK_BANK_STATS_EN adds a saturating 16-bit completed-command counter (op_count).
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask0,
    input  logic [WIDTH-1:0] mask1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`ifdef JK_BANK_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    state_e           state, state_nxt;
    logic             prio;
    logic [1:0]       grant;
    logic             win_idx;
    op_e              win_op;
    logic [WIDTH-1:0] win_mask;
    logic [WIDTH-1:0] j, k;

    jk_rr_arb u_arb (
        .req   (req),
        .prio  (prio),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                busy      = 1'b1;
                ack       = win_idx ? 2'b10 : 2'b01;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        j = '0;
        k = '0;
        case (win_op)
            OP_SET: j = win_mask;
            OP_CLR: k = win_mask;
            OP_TOG: begin
                j = win_mask;
                k = win_mask;
            end
            default: ;
        endcase
    end

    // Command is captured in IDLE so requester changes during EXEC/ACK have no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q        <= '0;
            prio     <= 1'b0;
            win_idx  <= 1'b0;
            win_op   <= OP_HOLD;
            win_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        win_idx  <= grant[1];
                        win_op   <= grant[1] ? op_e'(op1) : op_e'(op0);
                        win_mask <= grant[1] ? mask1 : mask0;
                    end
                end
                ST_EXEC: q    <= (j & ~q) | (~k & q);
                ST_ACK:  prio <= ~win_idx;
                default: ;
            endcase
        end
    end

    assign qn = ~q;

`ifdef JK_BANK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_count <= '0;
        end else if (state == ST_ACK && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: vector table of single commands plus arbitration/reset sequences.
module tb_jk_bank_arbiter;
    import jk_bank_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req, op0, op1, ack;
    logic [W-1:0] mask0, mask1, q, qn;
    logic         busy;
`ifdef JK_BANK_STATS_EN
    logic [15:0]  op_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op0   (op0),
        .op1   (op1),
        .mask0 (mask0),
        .mask1 (mask1),
        .ack   (ack),
        .busy  (busy),
        .q     (q),
        .qn    (qn)
`ifdef JK_BANK_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    typedef struct {
        logic       r;
        logic [1:0] op;
        logic [7:0] mask;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst   = 1'b0;
        tick();
        rst   = 1'b1;
    endtask

    task automatic single_cmd(input logic r, input logic [1:0] op, input logic [7:0] mask,
                              input logic [7:0] prev_q, input logic [7:0] exp_q);
        logic [7:0] exp_qn;
        exp_qn = ~exp_q;
        if (r) begin
            op1 = op; mask1 = mask; req = 2'b10;
        end else begin
            op0 = op; mask0 = mask; req = 2'b01;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_ack", {30'd0, ack}, 32'd0);
        check("exec_q", {24'd0, q}, {24'd0, prev_q});
        // changes during EXEC must be ignored
        op0 = ~op; op1 = ~op; mask0 = ~mask; mask1 = ~mask;
        tick();
        check("ack_q", {24'd0, q}, {24'd0, exp_q});
        check("ack_qn", {24'd0, qn}, {24'd0, exp_qn});
        check("ack_pulse", {30'd0, ack}, r ? 32'd2 : 32'd1);
        req = '0;
        tick();
        check("post_ack", {30'd0, ack}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   prev;
        logic [1:0]   exp_g;
        int           n;

        vecs[0] = '{1'b0, OP_SET,  8'h0F, 8'h0F};
        vecs[1] = '{1'b1, OP_TOG,  8'hFF, 8'hF0};
        vecs[2] = '{1'b0, OP_HOLD, 8'hFF, 8'hF0};
        vecs[3] = '{1'b1, OP_SET,  8'h00, 8'hF0};
        vecs[4] = '{1'b0, OP_CLR,  8'h30, 8'hC0};
        vecs[5] = '{1'b1, OP_TOG,  8'h81, 8'h41};
        vecs[6] = '{1'b0, OP_SET,  8'h0C, 8'h4D};

        rst = 1'b0; req = '0; op0 = '0; op1 = '0; mask0 = '0; mask1 = '0;
        tick();
        tick();
        check("rst_q", {24'd0, q}, 32'd0);
        check("rst_qn", {24'd0, qn}, 32'hFF);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_qn", {24'd0, qn}, 32'hFF);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        prev = 8'h00;
        for (int i = 0; i < 7; i++) begin
            single_cmd(vecs[i].r, vecs[i].op, vecs[i].mask, prev, vecs[i].exp_q);
            prev = vecs[i].exp_q;
        end
`ifdef JK_BANK_STATS_EN
        check("op_count", {16'd0, op_count}, 32'd7);
`endif

        // simultaneous request after requester 0 was served last
        do_reset();
        single_cmd(1'b0, OP_SET, 8'h0F, 8'h00, 8'h0F);
        op0 = OP_TOG; mask0 = 8'hFF; op1 = OP_CLR; mask1 = 8'h01; req = 2'b11;
        tick();
        check("tie_busy", {31'd0, busy}, 32'd1);
        tick();
        check("tie_q1", {24'd0, q}, 32'h0E);
        check("tie_ack1", {30'd0, ack}, 32'd2);
        req = 2'b01;
        tick();
        check("tie_idle_busy", {31'd0, busy}, 32'd0);
        check("tie_idle_ack", {30'd0, ack}, 32'd0);
        tick();
        check("tie_loser_busy", {31'd0, busy}, 32'd1);
        tick();
        check("tie_q0", {24'd0, q}, 32'hF1);
        check("tie_ack0", {30'd0, ack}, 32'd1);
        req = '0;
        tick();
        check("tie_end_busy", {31'd0, busy}, 32'd0);

        // both held continuously: grants alternate starting with requester 0
        do_reset();
        op0 = OP_HOLD; op1 = OP_HOLD; mask0 = '0; mask1 = '0; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (ack == 2'b00 && n < 6) begin
                tick();
                n++;
            end
            check("rr_grant", {30'd0, ack}, {30'd0, exp_g});
            tick();
        end
        req = '0;
        check("rr_q", {24'd0, q}, 32'd0);

        // reset during EXEC aborts the command
        do_reset();
        op0 = OP_SET; mask0 = 8'hFF; req = 2'b01;
        tick();
        check("abort_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        check("abort_q", {24'd0, q}, 32'd0);
        check("abort_qn", {24'd0, qn}, 32'hFF);
        check("abort_ack", {30'd0, ack}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1; req = '0;
        tick();
        check("abort_after_ack", {30'd0, ack}, 32'd0);
        check("abort_after_busy", {31'd0, busy}, 32'd0);
        check("abort_after_q", {24'd0, q}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
